obc_shift_acc: RTL and testbench

OBC_SHIFT_ACC -- requirements
Module: obc_shift_acc

---
 rtl/obc_pkg.sv | 14 +
 rtl/obc_psum_adder.sv | 39 +++
 rtl/obc_shift_acc.sv | 107 ++++++++++
 tb/tb_obc_shift_acc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obc_pkg.sv
// Shared constants and FSM encoding for the offset-binary-coded DFT
// shift-accumulator.
package obc_pkg;

  localparam int PW     = 32;
  localparam int NSLICE = 16;
  localparam int ACCW   = PW + 3 + NSLICE - 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/obc_psum_adder.sv
// Combinational sum of the eight signed ROM partial terms of one bit slice.
// Three guard bits make overflow of the 8-term sum impossible.
module obc_psum_adder #(
  parameter int PW = obc_pkg::PW
) (
  input  logic [PW-1:0] p0,
  input  logic [PW-1:0] p1,
  input  logic [PW-1:0] p2,
  input  logic [PW-1:0] p3,
  input  logic [PW-1:0] p4,
  input  logic [PW-1:0] p5,
  input  logic [PW-1:0] p6,
  input  logic [PW-1:0] p7,
  output logic [PW+2:0] psum
);

  logic [PW+2:0] e0, e1, e2, e3, e4, e5, e6, e7;
  logic [PW+2:0] s01, s23, s45, s67;
  logic [PW+2:0] s0123, s4567;

  assign e0 = {{3{p0[PW-1]}}, p0};
  assign e1 = {{3{p1[PW-1]}}, p1};
  assign e2 = {{3{p2[PW-1]}}, p2};
  assign e3 = {{3{p3[PW-1]}}, p3};
  assign e4 = {{3{p4[PW-1]}}, p4};
  assign e5 = {{3{p5[PW-1]}}, p5};
  assign e6 = {{3{p6[PW-1]}}, p6};
  assign e7 = {{3{p7[PW-1]}}, p7};

  // Balanced tree keeps the carry chain depth at three adders.
  assign s01   = e0 + e1;
  assign s23   = e2 + e3;
  assign s45   = e4 + e5;
  assign s67   = e6 + e7;
  assign s0123 = s01 + s23;
  assign s4567 = s45 + s67;
  assign psum  = s0123 + s4567;

endmodule

// File: rtl/obc_shift_acc.sv
// MSB-first shift-accumulator for an OBC distributed-arithmetic DFT bin.
// Slices are weighted -2^(N-1) for the sign slice and +2^k for the rest.
module obc_shift_acc #(
  parameter int NSLICE = obc_pkg::NSLICE,
  parameter int PW     = obc_pkg::PW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       slice_valid,
  input  logic [PW-1:0]              p0,
  input  logic [PW-1:0]              p1,
  input  logic [PW-1:0]              p2,
  input  logic [PW-1:0]              p3,
  input  logic [PW-1:0]              p4,
  input  logic [PW-1:0]              p5,
  input  logic [PW-1:0]              p6,
  input  logic [PW-1:0]              p7,
  input  logic [PW-1:0]              offset,
  output logic                       busy,
  output logic                       out_valid,
  output logic [PW+3+NSLICE-2:0]     y,
  output logic                       dbg_state
);

  import obc_pkg::*;

  localparam int AW = PW + 3 + NSLICE - 1;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Handshake: a slice is taken on a rising edge where busy=1,
  // slice_valid=1 and start=0; there is no backpressure, the source
  // simply holds slice_valid low to stall. start always wins.

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, acc_next;
  logic [PW+2:0] psum;
  logic [AW-1:0] psum_ext, off_ext;
  logic          accept, final_accept;

  obc_psum_adder #(.PW(PW)) u_adder (
    .p0   (p0),
    .p1   (p1),
    .p2   (p2),
    .p3   (p3),
    .p4   (p4),
    .p5   (p5),
    .p6   (p6),
    .p7   (p7),
    .psum (psum)
  );

  assign psum_ext = {{(AW-PW-3){psum[PW+2]}}, psum};
  assign off_ext  = {{(AW-PW){offset[PW-1]}}, offset};

  // First slice carries the negative sign weight; later ones shift in.
  assign acc_next = (cnt == '0) ? (AW'(0) - psum_ext)
                                : ({acc[AW-2:0], 1'b0} + psum_ext);

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    final_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACC;
      end
      ACC: begin
        if (!start && slice_valid) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            final_accept = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= final_accept;
      if (start) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= final_accept ? '0 : cnt + 1'b1;
        acc <= acc_next;
      end
      if (final_accept) y <= acc_next + off_ext;
    end
  end

  assign busy      = (state == ACC);
  assign dbg_state = state;

endmodule

// File: tb/tb_obc_shift_acc.sv
// Self-checking bench for obc_shift_acc: directed corner runs plus random
// runs compared against a weighted-sum reference model.
module tb_obc_shift_acc;

  localparam int PW = 32;
  localparam int NS = 16;
  localparam int AW = PW + 3 + NS - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          slice_valid = 1'b0;
  logic [PW-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [PW-1:0] p4 = '0, p5 = '0, p6 = '0, p7 = '0;
  logic [PW-1:0] offset = '0;
  logic          busy, out_valid, dbg_state;
  logic [AW-1:0] y;

  obc_shift_acc #(.NSLICE(NS), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .slice_valid (slice_valid),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .p4          (p4),
    .p5          (p5),
    .p6          (p6),
    .p7          (p7),
    .offset      (offset),
    .busy        (busy),
    .out_valid   (out_valid),
    .y           (y),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_count = 0;
  int busy_drop = 0;

  logic [PW-1:0] pv [NS][8];
  logic [AW-1:0] exp_q [$];

  always @(negedge clk) if (out_valid === 1'b1) ov_count++;

  // ---------------- reference model ----------------
  // y = sum_k w_k * (sum_j p_j of slice k) + offset, with the sign slice
  // weighted -2^(NS-1) and slice k>0 weighted +2^(NS-1-k).
  function automatic logic [AW-1:0] model_y(input logic [PW-1:0] off);
    longint s;
    longint ps;
    longint w;
    logic [63:0] r;
    s = 0;
    for (int k = 0; k < NS; k++) begin
      ps = 0;
      for (int j = 0; j < 8; j++) ps += longint'(signed'(pv[k][j]));
      w = (k == 0) ? -(64'sd1 <<< (NS - 1)) : (64'sd1 <<< (NS - 1 - k));
      s += ps * w;
    end
    s += longint'(signed'(off));
    r = s;
    return r[AW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_pv(input int mode, input logic [PW-1:0] v);
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 8; j++)
        pv[k][j] = (mode == 0) ? v : PW'($urandom);
  endtask

  task automatic drive_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_slice(input int k, input int gap_max);
    int g;
    g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (g) begin
      slice_valid = 1'b0;
      @(negedge clk);
      if (busy !== 1'b1) busy_drop++;
    end
    p0 = pv[k][0]; p1 = pv[k][1]; p2 = pv[k][2]; p3 = pv[k][3];
    p4 = pv[k][4]; p5 = pv[k][5]; p6 = pv[k][6]; p7 = pv[k][7];
    slice_valid = 1'b1;
    @(negedge clk);
    slice_valid = 1'b0;
    if (k != NS - 1 && busy !== 1'b1) busy_drop++;
  endtask

  task automatic drive_slices(input int gap_max);
    for (int k = 0; k < NS; k++) drive_slice(k, gap_max);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (y !== '0) begin n_fail++; $display("FAIL reset_y got %0h want 0", y); end
    n_tests++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b want 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    logic [AW-1:0] e;
    fill_pv(0, 32'd1);
    offset = '0;
    e = model_y(offset);
    drive_start();
    drive_slices(0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_out_valid got %b want 1", out_valid); end
    n_tests++; if (y !== e) begin n_fail++; $display("FAIL ones_y got %0h want %0h", y, e); end
    n_tests++; if (y !== AW'(-8)) begin n_fail++; $display("FAIL ones_y_m8 got %0h want %0h", y, AW'(-8)); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ones_busy_after got %b want 0", busy); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_pulse_width got %b want 0", out_valid); end
    n_tests++; if (y !== e) begin n_fail++; $display("FAIL ones_y_hold got %0h want %0h", y, e); end
  endtask

  task automatic test_msb_only();
    logic [AW-1:0] e;
    fill_pv(0, '0);
    pv[0][0] = 32'd1;
    offset = 32'd5;
    e = model_y(offset);
    drive_start();
    drive_slices(0);
    n_tests++; if (y !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL msb_y got %0h/%b want %0h/1", y, out_valid, e); end
    n_tests++; if (y !== AW'(-32763)) begin n_fail++; $display("FAIL msb_y_const got %0h want %0h", y, AW'(-32763)); end
    @(negedge clk);
  endtask

  task automatic test_lsb_gaps();
    int ov0;
    logic [AW-1:0] e;
    fill_pv(0, '0);
    pv[NS-1][0] = 32'd1;
    offset = '0;
    e = model_y(offset);
    drive_start();
    ov0 = ov_count;
    busy_drop = 0;
    for (int k = 0; k < NS - 1; k++) drive_slice(k, 3);
    n_tests++; if (ov_count != ov0) begin n_fail++; $display("FAIL gaps_early_ov got %0d want 0", ov_count - ov0); end
    drive_slice(NS - 1, 3);
    n_tests++; if (busy_drop != 0) begin n_fail++; $display("FAIL gaps_busy_drops got %0d want 0", busy_drop); end
    n_tests++; if (y !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_y got %0h/%b want %0h/1", y, out_valid, e); end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    logic [PW-1:0] vals [2];
    vals[0] = 32'h7FFF_FFFF;
    vals[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      fill_pv(0, vals[i]);
      offset = PW'($urandom);
      exp_q.push_back(model_y(offset));
      drive_start();
      drive_slices(0);
      n_tests++;
      if (out_valid !== 1'b1 || y !== exp_q[0]) begin
        n_fail++; $display("FAIL extreme_%0d got %0h/%b want %0h/1", i, y, out_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int ov0;
    logic [AW-1:0] e;
    fill_pv(1, '0);
    ov0 = ov_count;
    drive_start();
    for (int k = 0; k < 7; k++) drive_slice(k, 1);
    // restart with a junk slice offered in the same cycle
    p0 = PW'($urandom); p1 = PW'($urandom);
    start = 1'b1; slice_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; slice_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", busy); end
    fill_pv(1, '0);
    offset = PW'($urandom);
    e = model_y(offset);
    drive_slices(1);
    n_tests++; if (y !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_y got %0h/%b want %0h/1", y, out_valid, e); end
    @(negedge clk);
    n_tests++; if (ov_count - ov0 != 1) begin n_fail++; $display("FAIL abort_ov_count got %0d want 1", ov_count - ov0); end
  endtask

  task automatic test_rst_mid();
    int ov0;
    fill_pv(1, '0);
    drive_start();
    for (int k = 0; k < 5; k++) drive_slice(k, 0);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || y !== '0) begin
      n_fail++; $display("FAIL rst_mid got busy=%b ov=%b y=%0h want 0/0/0", busy, out_valid, y);
    end
    @(negedge clk);
    rst = 1'b0;
    ov0 = ov_count;
    for (int k = 0; k < NS + 2; k++) drive_slice(k % NS, 0);
    @(negedge clk);
    n_tests++; if (ov_count != ov0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_start got ov=%0d busy=%b want 0/0", ov_count - ov0, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] e;
    fill_pv(1, '0);
    offset = PW'($urandom);
    e = model_y(offset);
    drive_start();
    drive_slices(0);
    for (int r = 0; r < 4; r++) begin
      n_tests++; if (y !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d got %0h/%b want %0h/1", r, y, out_valid, e); end
      // next start coincides with out_valid
      fill_pv(1, '0);
      offset = PW'($urandom);
      e = model_y(offset);
      drive_start();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_%0d got %b want 1", r, busy); end
      drive_slices((r % 2) * 2);
    end
    n_tests++; if (y !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last got %0h/%b want %0h/1", y, out_valid, e); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_all_ones();
    test_msb_only();
    test_lsb_gaps();
    test_extremes();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
